// File: rtl/instr_register_fifo_pkg.sv
// Shared opcode type and default sizing for the instruction register FIFO.
package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam int OPCODE_W      = 3;
  localparam int OPERAND_W_DEF = 32;
  localparam int DEPTH_DEF     = 32;

endpackage

// File: rtl/instr_register_fifo_alu.sv
// Combinational signed ALU producing a double-width result for a pushed instruction.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter int OPERAND_W = OPERAND_W_DEF
) (
  input  opcode_t                       opcode,
  input  logic signed [OPERAND_W-1:0]   operand_a,
  input  logic signed [OPERAND_W-1:0]   operand_b,
  output logic signed [2*OPERAND_W-1:0] result
);

  localparam int RES_W = 2 * OPERAND_W;

  function automatic logic signed [RES_W-1:0] sext(input logic signed [OPERAND_W-1:0] v);
    return {{OPERAND_W{v[OPERAND_W-1]}}, v};
  endfunction

  logic signed [RES_W-1:0] a_x;
  logic signed [RES_W-1:0] b_x;
  logic                    b_zero;

  // Working at double width keeps MULT exact and the min/-1 quotient representable.
  always_comb begin
    a_x    = sext(operand_a);
    b_x    = sext(operand_b);
    b_zero = (operand_b == '0);
    result = '0;
    case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_x;
      PASSB: result = b_x;
      ADD:   result = a_x + b_x;
      SUB:   result = a_x - b_x;
      MULT:  result = a_x * b_x;
      DIV:   result = b_zero ? '0 : (a_x / b_x);
      MOD:   result = b_zero ? '0 : (a_x % b_x);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/instr_register_fifo.sv
// Circular-buffer instruction FIFO with registered pop and sticky error flags.
// Define INSTR_RESULT_EN to compute and store the ALU result; otherwise result is 0.
module instr_register_fifo
  import instr_register_pkg::*;
#(
  parameter  int OPERAND_W = OPERAND_W_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH) + 1,
  localparam int INSTR_W   = OPCODE_W + 4 * OPERAND_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        load_en,
  input  opcode_t                     opcode,
  input  logic signed [OPERAND_W-1:0] operand_a,
  input  logic signed [OPERAND_W-1:0] operand_b,
  input  logic                        read_en,
  output logic [INSTR_W-1:0]          instruction_word,
  output logic                        instr_valid,
  output logic [CNT_W-1:0]            count,
  output logic                        full,
  output logic                        empty,
  output logic                        push_err,
  output logic                        pop_err
);

  typedef struct packed {
    opcode_t                       opcode;
    logic signed [OPERAND_W-1:0]   operand_a;
    logic signed [OPERAND_W-1:0]   operand_b;
    logic signed [2*OPERAND_W-1:0] result;
  } instr_t;

  instr_t                        mem [DEPTH];
  instr_t                        entry_p0;
  instr_t                        instr_p1;
  logic                          vld_p1;
  logic signed [2*OPERAND_W-1:0] result_p0;
  logic [PTR_W-1:0]              write_pointer;
  logic [PTR_W-1:0]              read_pointer;
  logic [CNT_W-1:0]              cnt;
  logic                          push_ok;
  logic                          pop_ok;

`ifdef INSTR_RESULT_EN
  instr_alu #(
    .OPERAND_W (OPERAND_W)
  ) u_alu (
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result_p0)
  );
`else
  assign result_p0 = '0;
`endif

  // Stage p0: assemble the entry to be written at push time.
  always_comb begin
    entry_p0           = '0;
    entry_p0.opcode    = opcode;
    entry_p0.operand_a = operand_a;
    entry_p0.operand_b = operand_b;
    entry_p0.result    = result_p0;
  end

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // A pop frees a slot this cycle, so a full buffer still takes the push.
  assign pop_ok  = read_en && !empty;
  assign push_ok = load_en && (!full || pop_ok);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[write_pointer] <= entry_p0;
    end
  end

  // Stage p1: registered pop output plus all control state.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_pointer <= '0;
      read_pointer  <= '0;
      cnt           <= '0;
      vld_p1        <= 1'b0;
      instr_p1      <= '0;
      push_err      <= 1'b0;
      pop_err       <= 1'b0;
    end else begin
      vld_p1 <= pop_ok;
      if (pop_ok) begin
        instr_p1     <= mem[read_pointer];
        read_pointer <= read_pointer + PTR_W'(1);
      end
      if (push_ok) begin
        write_pointer <= write_pointer + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
      if (load_en && !push_ok) push_err <= 1'b1;
      if (read_en && !pop_ok)  pop_err  <= 1'b1;
    end
  end

  assign instruction_word = instr_p1;
  assign instr_valid      = vld_p1;
  assign count            = cnt;

endmodule
